nqueens_solver: RTL and testbench

- Parametrised, self-sequencing N-queens solver: column-by-column backtracking search with an on-chip row stack and a registered controller.
- Conflicts are detected incrementally with row/diagonal occupancy masks, so no population counting is needed.
- Streams each complete placement over a valid/ready port.
- Supports first-solution or enumerate-all modes and keeps a saturating solution count.

---
 rtl/nq_pkg.sv | 20 ++
 rtl/nqueens_solver_if.sv | 27 ++
 rtl/nq_stack.sv | 34 +++
 rtl/nqueens_solver.sv | 181 ++++++++++++++++++
 tb/tb_nqueens_solver.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nq_pkg.sv
// Shared types and index helpers for the N-queens solver.
package nq_pkg;

  typedef enum logic [2:0] {IDLE, SCAN, BACK, EMIT, DONE} nq_state_e;

  function automatic int nq_w(input int n);
    return $clog2(n);
  endfunction

  // Rising diagonal: constant row+col.
  function automatic int d1_idx(input int row, input int col);
    return row + col;
  endfunction

  // Falling diagonal: constant row-col, offset so the index is never negative.
  function automatic int d2_idx(input int row, input int col, input int n);
    return row - col + n - 1;
  endfunction

endpackage

// File: rtl/nqueens_solver_if.sv
// Control and placement-stream bundle between a requester and the N-queens solver.
interface nqueens_solver_if #(
  parameter int N     = 8,
  parameter int W     = nq_pkg::nq_w(N),
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode;
  logic             abort;
  logic             busy;
  logic             done;
  logic             sol_valid;
  logic             sol_ready;
  logic [N*W-1:0]   sol_rows;
  logic [CNT_W-1:0] sol_count;
  logic             found;

  modport master (
    output start, mode, abort, sol_ready,
    input  busy, done, sol_valid, sol_rows, sol_count, found
  );

  modport slave (
    input  start, mode, abort, sol_ready,
    output busy, done, sol_valid, sol_rows, sol_count, found
  );
endinterface

// File: rtl/nq_stack.sv
// Per-column row stack: one synchronous write port, two combinational reads, flat view.
// Latency: write visible the cycle after wr_en; no flow control of its own.
module nq_stack #(
  parameter int N = 8,
  parameter int W = nq_pkg::nq_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [W-1:0]   wr_idx,
  input  logic [W-1:0]   wr_dat,
  input  logic [W-1:0]   rd_idx,
  output logic [W-1:0]   rd_dat,
  output logic [W-1:0]   last_dat,
  output logic [N*W-1:0] flat
);
  logic [W-1:0] mem [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat   = mem[rd_idx];
  assign last_dat = mem[N-1];

  always_comb begin
    flat = '0;
    for (int i = 0; i < N; i++) flat[i*W +: W] = mem[i];
  end
endmodule

// File: rtl/nqueens_solver.sv
// Column-by-column backtracking N-queens search, one candidate row per cycle.
// Placements stream on sol_valid/sol_ready; a stalled consumer freezes the search in EMIT.
module nqueens_solver #(
  parameter int N     = 8,
  parameter int W     = nq_pkg::nq_w(N),
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  nqueens_solver_if.slave  bus
);
  import nq_pkg::*;

  localparam int DN = 2*N - 1;
  localparam int DW = $clog2(DN);

  if (N < 4 || N > 16) begin : g_bad_n
    $error("nqueens_solver: N must be in 4..16");
  end

  nq_state_e        state, state_nxt;
  logic             mode_q;
  logic [W-1:0]     col;
  logic [W:0]       row;
  logic [N-1:0]     row_mask;
  logic [DN-1:0]    d1_mask, d2_mask;
  logic [N*W-1:0]   sol_rows_q, sol_rows_nxt, stk_flat;
  logic [CNT_W-1:0] sol_count_q;

  logic [W-1:0]  cur_r, pop_col, stk_rd, stk_last;
  logic [DW-1:0] d1_cur, d2_cur, d1_pop, d2_pop, d1_last, d2_last;
  logic          row_end, last_col, safe;
  logic          do_init, do_place, do_adv, do_back, do_pop, do_cnt;

  assign cur_r    = row[W-1:0];
  assign pop_col  = col - W'(1);
  assign row_end  = (row == (W+1)'(N));
  assign last_col = (col == W'(N-1));

  assign d1_cur  = DW'(d1_idx(int'(cur_r), int'(col)));
  assign d2_cur  = DW'(d2_idx(int'(cur_r), int'(col), N));
  assign d1_pop  = DW'(d1_idx(int'(stk_rd), int'(pop_col)));
  assign d2_pop  = DW'(d2_idx(int'(stk_rd), int'(pop_col), N));
  assign d1_last = DW'(d1_idx(int'(stk_last), N-1));
  assign d2_last = DW'(d2_idx(int'(stk_last), N-1, N));

  assign safe = !row_mask[cur_r] && !d1_mask[d1_cur] && !d2_mask[d2_cur];

  nq_stack #(.N(N), .W(W)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (do_place),
    .wr_idx   (col),
    .wr_dat   (cur_r),
    .rd_idx   (pop_col),
    .rd_dat   (stk_rd),
    .last_dat (stk_last),
    .flat     (stk_flat)
  );

  // The final column's row is still being written, so splice it in directly.
  always_comb begin
    sol_rows_nxt = stk_flat;
    sol_rows_nxt[(N-1)*W +: W] = cur_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_init   = 1'b0;
    do_place  = 1'b0;
    do_adv    = 1'b0;
    do_back   = 1'b0;
    do_pop    = 1'b0;
    do_cnt    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        do_init   = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        if (row_end) begin
          state_nxt = BACK;
        end else if (safe) begin
          do_place = 1'b1;
          if (last_col) state_nxt = EMIT;
        end else begin
          do_adv = 1'b1;
        end
      end
      BACK: begin
        if (col == '0) begin
          state_nxt = DONE;
        end else begin
          do_back   = 1'b1;
          state_nxt = SCAN;
        end
      end
      EMIT: if (bus.sol_ready) begin
        do_cnt = 1'b1;
        if (!mode_q) begin
          state_nxt = DONE;
        end else begin
          do_pop    = 1'b1;
          state_nxt = SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every search transition, including a pending handshake.
    if (bus.abort && (state == SCAN || state == BACK || state == EMIT)) begin
      state_nxt = DONE;
      do_place  = 1'b0;
      do_adv    = 1'b0;
      do_back   = 1'b0;
      do_pop    = 1'b0;
      do_cnt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= 1'b0;
      col         <= '0;
      row         <= '0;
      row_mask    <= '0;
      d1_mask     <= '0;
      d2_mask     <= '0;
      sol_rows_q  <= '0;
      sol_count_q <= '0;
    end else begin
      if (do_init) begin
        mode_q      <= bus.mode;
        col         <= '0;
        row         <= '0;
        row_mask    <= '0;
        d1_mask     <= '0;
        d2_mask     <= '0;
        sol_count_q <= '0;
      end
      if (do_place) begin
        row_mask[cur_r]  <= 1'b1;
        d1_mask[d1_cur]  <= 1'b1;
        d2_mask[d2_cur]  <= 1'b1;
        if (last_col) begin
          sol_rows_q <= sol_rows_nxt;
        end else begin
          col <= col + W'(1);
          row <= '0;
        end
      end
      if (do_adv) row <= row + (W+1)'(1);
      if (do_back) begin
        col              <= pop_col;
        row_mask[stk_rd] <= 1'b0;
        d1_mask[d1_pop]  <= 1'b0;
        d2_mask[d2_pop]  <= 1'b0;
        row              <= {1'b0, stk_rd} + (W+1)'(1);
      end
      if (do_pop) begin
        row_mask[stk_last] <= 1'b0;
        d1_mask[d1_last]   <= 1'b0;
        d2_mask[d2_last]   <= 1'b0;
        row                <= {1'b0, stk_last} + (W+1)'(1);
      end
      if (do_cnt && sol_count_q != '1) sol_count_q <= sol_count_q + CNT_W'(1);
    end
  end

  assign bus.busy      = (state == SCAN) || (state == BACK) || (state == EMIT);
  assign bus.done      = (state == DONE);
  assign bus.sol_valid = (state == EMIT);
  assign bus.sol_rows  = sol_rows_q;
  assign bus.sol_count = sol_count_q;
  assign bus.found     = |sol_count_q;
endmodule

// File: tb/tb_nqueens_solver.sv
// Directed bench for nqueens_solver: small boards, full 8-queens enumeration, stalls, abort, reset.
module tb_nqueens_solver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nqueens_solver_if #(.N(8))             bus8  ();
  nqueens_solver_if #(.N(4))             bus4  ();
  nqueens_solver_if #(.N(5))             bus5  ();
  nqueens_solver_if #(.N(6))             bus6  ();
  nqueens_solver_if #(.N(8), .CNT_W(4))  bus8s ();

  nqueens_solver #(.N(8))            u8  (.clk(clk), .rst(rst), .bus(bus8));
  nqueens_solver #(.N(4))            u4  (.clk(clk), .rst(rst), .bus(bus4));
  nqueens_solver #(.N(5))            u5  (.clk(clk), .rst(rst), .bus(bus5));
  nqueens_solver #(.N(6))            u6  (.clk(clk), .rst(rst), .bus(bus6));
  nqueens_solver #(.N(8), .CNT_W(4)) u8s (.clk(clk), .rst(rst), .bus(bus8s));

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;  // 0: always ready, 1: ready ~30% of cycles, 2: never ready
  logic [23:0] q_run[$];
  int stall_cyc = 0, stall_viol = 0;
  int done4 = 0, done5 = 0, done6 = 0, done8s = 0;
  int hs4 = 0, hs5 = 0, hs6 = 0, hs8s = 0;
  logic [7:0]  rows4 = '0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_rows = '0;

  int first8[8] = '{0, 4, 7, 5, 2, 6, 1, 3};
  int last8[8]  = '{7, 3, 0, 2, 5, 1, 6, 4};
  int sol4[4]   = '{1, 3, 0, 2};
  logic [23:0] ref8[92];
  logic [23:0] e_first, e_last, s, sp;
  logic [7:0]  e4;
  bit ok;
  int base, n, bad_att, bad_ord, bad_ref, sc0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack8(input int r[8]);
    logic [23:0] p;
    p = '0;
    for (int c = 0; c < 8; c++) p[c*3 +: 3] = 3'(r[c]);
    return p;
  endfunction

  function automatic bit attack_free(input logic [23:0] v);
    int r[8];
    for (int c = 0; c < 8; c++) r[c] = int'(v[c*3 +: 3]);
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (r[i] == r[j] || r[i] - r[j] == j - i || r[j] - r[i] == j - i) return 1'b0;
    return 1'b1;
  endfunction

  // Column 0 is the most significant digit of the search order.
  function automatic longint key8(input logic [23:0] v);
    longint k;
    k = 0;
    for (int c = 0; c < 8; c++) k = k * 8 + longint'(v[c*3 +: 3]);
    return k;
  endfunction

  task automatic start8(input logic m);
    @(posedge clk); #1;
    bus8.mode  = m;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bus8.sol_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus8.sol_ready = 1'b1;
        1:       bus8.sol_ready = ($urandom_range(0, 9) >= 7);
        default: bus8.sol_ready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus8.sol_valid && bus8.sol_ready && !bus8.abort) q_run.push_back(bus8.sol_rows);
    if (bus8.sol_valid && prev_stall && bus8.sol_rows !== prev_rows) stall_viol++;
    if (bus8.sol_valid && !bus8.sol_ready) stall_cyc++;
    prev_stall = bus8.sol_valid && !bus8.sol_ready && !bus8.abort;
    prev_rows  = bus8.sol_rows;
    if (bus4.done)  done4++;
    if (bus5.done)  done5++;
    if (bus6.done)  done6++;
    if (bus8s.done) done8s++;
    if (bus4.sol_valid && bus4.sol_ready) begin hs4++; rows4 = bus4.sol_rows; end
    if (bus5.sol_valid && bus5.sol_ready) hs5++;
    if (bus6.sol_valid && bus6.sol_ready) hs6++;
    if (bus8s.sol_valid && bus8s.sol_ready) hs8s++;
  end

  initial begin
    e_first = pack8(first8);
    e_last  = pack8(last8);
    e4 = '0;
    for (int c = 0; c < 4; c++) e4[c*2 +: 2] = 2'(sol4[c]);

    rst = 1'b0;
    bus8.start = 1'b0;  bus8.mode = 1'b0;  bus8.abort = 1'b0;
    bus4.start = 1'b0;  bus4.mode = 1'b0;  bus4.abort = 1'b0;  bus4.sol_ready = 1'b1;
    bus5.start = 1'b0;  bus5.mode = 1'b0;  bus5.abort = 1'b0;  bus5.sol_ready = 1'b1;
    bus6.start = 1'b0;  bus6.mode = 1'b0;  bus6.abort = 1'b0;  bus6.sol_ready = 1'b1;
    bus8s.start = 1'b0; bus8s.mode = 1'b0; bus8s.abort = 1'b0; bus8s.sol_ready = 1'b1;

    #3;
    check("rst_busy",  64'(bus8.busy),      64'd0);
    check("rst_done",  64'(bus8.done),      64'd0);
    check("rst_valid", 64'(bus8.sol_valid), 64'd0);
    check("rst_rows",  64'(bus8.sol_rows),  64'd0);
    check("rst_count", 64'(bus8.sol_count), 64'd0);
    check("rst_found", 64'(bus8.found),     64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Small boards side by side: N=4 first solution, N=5 and N=6 enumerate all.
    @(posedge clk); #1;
    bus4.mode = 1'b0; bus5.mode = 1'b1; bus6.mode = 1'b1;
    bus4.start = 1'b1; bus5.start = 1'b1; bus6.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus5.start = 1'b0; bus6.start = 1'b0;
    for (int i = 0; i < 20000 && (done4 == 0 || done5 == 0 || done6 == 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("n4_done_once", 64'(done4),          64'd1);
    check("n4_handshakes", 64'(hs4),           64'd1);
    check("n4_rows",      64'(rows4),          64'(e4));
    check("n4_rows_held", 64'(bus4.sol_rows),  64'(e4));
    check("n4_count",     64'(bus4.sol_count), 64'd1);
    check("n4_found",     64'(bus4.found),     64'd1);
    check("n4_busy_low",  64'(bus4.busy),      64'd0);
    check("n5_count",     64'(bus5.sol_count), 64'd10);
    check("n5_handshakes", 64'(hs5),           64'd10);
    check("n6_count",     64'(bus6.sol_count), 64'd4);
    check("n6_handshakes", 64'(hs6),           64'd4);

    // N=8 first solution only.
    base = q_run.size();
    start8(1'b0);
    @(negedge clk);
    check("n8m0_busy", 64'(bus8.busy), 64'd1);
    wait_done8(5000, ok);
    check("n8m0_done", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    check("n8m0_nsol",  64'(q_run.size() - base), 64'd1);
    if (q_run.size() > base) check("n8m0_first", 64'(q_run[base]), 64'(e_first));
    check("n8m0_count", 64'(bus8.sol_count), 64'd1);
    check("n8m0_found", 64'(bus8.found),     64'd1);
    check("n8m0_busy_low", 64'(bus8.busy),   64'd0);
    check("n8m0_rows_held", 64'(bus8.sol_rows), 64'(e_first));

    // Full enumeration, with a 4-bit-counter twin running alongside.
    base = q_run.size();
    @(posedge clk); #1;
    bus8.mode = 1'b1;  bus8.start = 1'b1;
    bus8s.mode = 1'b1; bus8s.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8s.start = 1'b0;
    wait_done8(60000, ok);
    check("n8m1_done", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    n = q_run.size() - base;
    check("n8m1_nsol",  64'(n), 64'd92);
    check("n8m1_count", 64'(bus8.sol_count), 64'd92);
    bad_att = 0; bad_ord = 0;
    for (int i = 0; i < n; i++) begin
      s = q_run[base + i];
      if (!attack_free(s)) bad_att++;
      if (i > 0 && key8(s) <= key8(sp)) bad_ord++;
      if (i < 92) ref8[i] = s;
      sp = s;
    end
    check("n8m1_attacks", 64'(bad_att), 64'd0);
    check("n8m1_order",   64'(bad_ord), 64'd0);
    if (n > 0) check("n8m1_last", 64'(q_run[base + n - 1]), 64'(e_last));
    check("sat_done_once",  64'(done8s),          64'd1);
    check("sat_handshakes", 64'(hs8s),            64'd92);
    check("sat_count",      64'(bus8s.sol_count), 64'hF);
    check("sat_found",      64'(bus8s.found),     64'd1);

    // Same enumeration under heavy backpressure; a mid-run start must be ignored.
    ready_mode = 1;
    sc0  = stall_cyc;
    base = q_run.size();
    start8(1'b1);
    for (int i = 0; i < 30000 && (q_run.size() - base) < 20; i++) @(negedge clk);
    @(posedge clk); #1;
    bus8.mode = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    wait_done8(60000, ok);
    ready_mode = 0;
    check("stall_done", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    n = q_run.size() - base;
    check("stall_nsol",  64'(n), 64'd92);
    check("stall_count", 64'(bus8.sol_count), 64'd92);
    bad_ref = 0;
    for (int i = 0; i < n && i < 92; i++) if (q_run[base + i] !== ref8[i]) bad_ref++;
    check("stall_same_order", 64'(bad_ref), 64'd0);
    check("stall_rows_stable", 64'(stall_viol), 64'd0);
    check("stall_seen", 64'(stall_cyc > sc0), 64'd1);

    // Abort while scanning.
    start8(1'b1);
    repeat (5) @(posedge clk);
    #1 bus8.abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_scan_done", 64'(bus8.done), 64'd1);
    check("abort_scan_busy", 64'(bus8.busy), 64'd0);
    @(posedge clk); #1;
    bus8.abort = 1'b0;
    @(negedge clk);
    check("abort_scan_pulse", 64'(bus8.done), 64'd0);

    // Abort in the same cycle the consumer finally accepts.
    ready_mode = 2;
    @(negedge clk);
    base = q_run.size();
    start8(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus8.sol_valid) begin ok = 1'b1; break; end
    end
    check("abort_emit_valid", 64'(ok), 64'd1);
    check("abort_emit_rows", 64'(bus8.sol_rows), 64'(e_first));
    ready_mode = 0;
    @(posedge clk); #1;
    bus8.abort = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_emit_valid_low", 64'(bus8.sol_valid), 64'd0);
    check("abort_emit_done",  64'(bus8.done),      64'd1);
    check("abort_emit_count", 64'(bus8.sol_count), 64'd0);
    check("abort_emit_found", 64'(bus8.found),     64'd0);
    check("abort_emit_nsol",  64'(q_run.size() - base), 64'd0);
    @(posedge clk); #1;
    bus8.abort = 1'b0;

    start8(1'b0);
    wait_done8(5000, ok);
    check("restart_done", 64'(ok), 64'd1);
    @(negedge clk);
    check("restart_count", 64'(bus8.sol_count), 64'd1);
    check("restart_rows",  64'(bus8.sol_rows),  64'(e_first));

    // Asynchronous reset in the middle of an enumeration.
    start8(1'b1);
    for (int i = 0; i < 20000 && bus8.sol_count < 3; i++) @(negedge clk);
    check("mid_progress", 64'(bus8.sol_count >= 3), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy",  64'(bus8.busy),      64'd0);
    check("arst_valid", 64'(bus8.sol_valid), 64'd0);
    check("arst_done",  64'(bus8.done),      64'd0);
    check("arst_count", 64'(bus8.sol_count), 64'd0);
    check("arst_found", 64'(bus8.found),     64'd0);
    check("arst_rows",  64'(bus8.sol_rows),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_stays_idle", 64'(bus8.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
